// File: rtl/uart_jtag_bitbang_pkg.sv
// uart_jtag_bitbang_pkg: remote-bitbang command bytes, response bytes and FSM encoding
package uart_jtag_bitbang_pkg;
  localparam logic [7:0] CMD_WR_BASE  = 8'h30;
  localparam logic [7:0] CMD_READ     = 8'h52;
  localparam logic [7:0] CMD_RST_BASE = 8'h72;
  localparam logic [7:0] CMD_LED_ON   = 8'h42;
  localparam logic [7:0] CMD_LED_OFF  = 8'h62;
  localparam logic [7:0] RESP_0       = 8'h30;
  localparam logic [7:0] RESP_1       = 8'h31;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RESP} state_t;
endpackage

// File: rtl/uart_jtag_bitbang_sync_1bit.sv
// sync_1bit: STAGES-deep flop chain bringing an asynchronous bit into the clk domain
module sync_1bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], i_d};
  end
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/uart_jtag_bitbang.sv
// uart_jtag_bitbang: decodes remote-bitbang command bytes into JTAG pin writes and tdo reads
module uart_jtag_bitbang
  import uart_jtag_bitbang_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tck,
  output logic       tms,
  output logic       tdi,
  input  logic       tdo,
  output logic       trst_n,
  output logic       srst_n,
  output logic       led
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_tx_data;
  logic r_tx_valid, r_tck, r_tms, r_tdi, r_trst_n, r_srst_n, r_led;
  logic w_tdo, w_acc, w_wr, w_rd, w_rc;
  logic [1:0] w_ridx;
  sync_1bit #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .i_d(tdo), .o_q(w_tdo));
  assign rx_ready = r_state == S_IDLE && !rst;
  assign w_acc    = rx_valid && rx_ready;
  assign w_wr     = rx_data[7:3] == CMD_WR_BASE[7:3];
  assign w_rd     = rx_data == CMD_READ;
  assign w_rc     = rx_data >= CMD_RST_BASE && rx_data <= CMD_RST_BASE + 8'd3;
  assign w_ridx   = 2'(rx_data - CMD_RST_BASE);
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = !w_acc ? S_IDLE : w_rd ? S_RESP : (w_wr && HOLD_CYCLES != 0) ? S_HOLD : S_IDLE;
      S_HOLD:  w_next = r_cnt == '0 ? S_IDLE : S_HOLD;
      S_RESP:  w_next = tx_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  // Pins and the response are registered; they only move on an accepted command or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_tck, r_tms, r_tdi} <= 3'b010;
      {r_trst_n, r_srst_n}  <= 2'b11;
      r_led      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_acc && w_wr) {r_tck, r_tms, r_tdi} <= rx_data[2:0];
      if (w_acc && w_rc) {r_trst_n, r_srst_n} <= ~w_ridx;
      if (w_acc && rx_data == CMD_LED_ON) r_led <= 1'b1;
      if (w_acc && rx_data == CMD_LED_OFF) r_led <= 1'b0;
      if (w_acc && w_rd) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_tdo ? RESP_1 : RESP_0;
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      r_cnt <= r_state == S_HOLD ? r_cnt - CW'(1) : HOLD_INIT;
    end
  end
  assign {tck, tms, tdi}  = {r_tck, r_tms, r_tdi};
  assign {trst_n, srst_n} = {r_trst_n, r_srst_n};
  assign led      = r_led;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_jtag_bitbang.sv
// tb_uart_jtag_bitbang: directed plus randomized command streams checked against a pin/response model
module tb_uart_jtag_bitbang;
  localparam int H = 4;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, rx_ready, tx_valid, tx_ready = 0, tdo = 0;
  logic tck, tms, tdi, trst_n, srst_n, led;
  logic [7:0] rx_data0 = 0, tx_data0;
  logic rx_valid0 = 0, rx_ready0, tx_valid0, tx_ready0 = 1;
  logic tck0, tms0, tdi0, trst_n0, srst_n0, led0;
  logic m_tck, m_tms, m_tdi, m_trst_n, m_srst_n, m_led;
  int n_chk = 0, n_fail = 0, n_acc = 0, n_resp = 0, n_sent = 0, n_rexp = 0;
  logic [7:0] seq [3];
  uart_jtag_bitbang #(.HOLD_CYCLES(H), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tck(tck), .tms(tms),
    .tdi(tdi), .tdo(tdo), .trst_n(trst_n), .srst_n(srst_n), .led(led));
  uart_jtag_bitbang #(.HOLD_CYCLES(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tck(tck0), .tms(tms0),
    .tdi(tdi0), .tdo(tdo), .trst_n(trst_n0), .srst_n(srst_n0), .led(led0));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rx_valid && rx_ready) n_acc++;
    if (tx_valid && tx_ready) n_resp++;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    {m_tck, m_tms, m_tdi, m_trst_n, m_srst_n, m_led} = 6'b010110;
  endtask
  task automatic check_pins(input string tag);
    chk(tag, {26'd0, tck, tms, tdi, trst_n, srst_n, led},
        {26'd0, m_tck, m_tms, m_tdi, m_trst_n, m_srst_n, m_led});
  endtask
  // Called at a negedge; returns at a negedge with the command fully retired.
  task automatic send(input logic [7:0] b, input logic et, input int k);
    int n = 0;
    int v = int'(b);
    logic [7:0] er;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, n < 50}, 1);
    @(negedge clk);
    rx_valid = 0;
    rx_data = 8'($urandom);
    n_sent++;
    if (v >= 'h30 && v <= 'h37) begin
      m_tck = (v - 'h30) >= 4;
      m_tms = ((v - 'h30) / 2) % 2 == 1;
      m_tdi = (v - 'h30) % 2 == 1;
    end
    if (v >= 'h72 && v <= 'h75) begin
      m_trst_n = (v - 'h72) < 2;
      m_srst_n = (v - 'h72) % 2 == 0;
    end
    if (v == 'h42) m_led = 1;
    if (v == 'h62) m_led = 0;
    check_pins("pins");
    if (v == 'h52) begin
      er = et ? 8'h31 : 8'h30;
      n_rexp++;
      for (int i = 0; i <= k; i++) begin
        chk("resp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, er});
        chk("resp_busy", {31'd0, rx_ready}, 0);
        @(negedge clk);
      end
      check_pins("pins_resp");
      tx_ready = 1;
      @(negedge clk);
      tx_ready = 0;
      chk("resp_done", {30'd0, tx_valid, rx_ready}, 1);
    end else if (v >= 'h30 && v <= 'h37) begin
      for (int i = 0; i < H; i++) begin
        chk("hold_busy", {31'd0, rx_ready}, 0);
        @(negedge clk);
      end
      chk("hold_end", {30'd0, rx_ready, tx_valid}, 2);
    end else begin
      chk("idle_after", {30'd0, rx_ready, tx_valid}, 2);
    end
  endtask
  initial begin
    seq[0] = 8'h31; seq[1] = 8'h33; seq[2] = 8'h30;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {30'd0, rx_ready, rx_ready0}, 0);
    end
    rst = 0;
    repeat (5) @(negedge clk);
    check_pins("reset_pins");
    chk("reset_tx", {23'd0, tx_valid, tx_data}, 0);
    chk("reset_ready", {30'd0, rx_ready, rx_ready0}, 3);
    chk("reset_pins0", {26'd0, tck0, tms0, tdi0, trst_n0, srst_n0, led0}, 6'b010110);
    send(8'h35, 0, 0);
    tdo = 1;
    repeat (3) @(negedge clk);
    send(8'h52, 1, 10);
    tdo = 0;
    repeat (3) @(negedge clk);
    send(8'h52, 0, 10);
    send(8'h74, 0, 0);
    send(8'h75, 0, 0);
    send(8'h72, 0, 0);
    send(8'h42, 0, 0);
    send(8'h62, 0, 0);
    send(8'h51, 0, 0);
    // tdo boundary: an 'R' accepted on the first edge after a change still sees the old value
    tdo = 1;
    send(8'h52, 0, 2);
    tdo = 0;
    repeat (2) @(negedge clk);
    send(8'h52, 0, 2);
    rx_valid0 = 1;
    for (int i = 0; i < 3; i++) begin
      rx_data0 = seq[i];
      chk("stream_ready", {31'd0, rx_ready0}, 1);
      @(negedge clk);
      chk("stream_pins", {29'd0, tck0, tms0, tdi0}, {29'd0, seq[i][2:0]});
    end
    rx_valid0 = 0;
    send(8'h36, 0, 0);
    send(8'h73, 0, 0);
    send(8'h42, 0, 0);
    rx_data = 8'h52;
    rx_valid = 1;
    chk("midresp_ready", {31'd0, rx_ready}, 1);
    @(negedge clk);
    rx_valid = 0;
    n_sent++;
    chk("midresp_valid", {31'd0, tx_valid}, 1);
    rst = 1;
    @(negedge clk);
    model_reset();
    chk("rst_drop", {30'd0, tx_valid, rx_ready}, 0);
    check_pins("rst_pins");
    rst = 0;
    @(negedge clk);
    send(8'h52, tdo, 3);
    for (int it = 0; it < 60; it++) begin
      int r = $urandom_range(0, 9);
      logic [7:0] b;
      if (r <= 3) b = 8'(8'h30 + $urandom_range(0, 7));
      else if (r == 4) begin
        tdo = 1'($urandom);
        repeat (3) @(negedge clk);
        b = 8'h52;
      end
      else if (r == 5) b = 8'(8'h72 + $urandom_range(0, 3));
      else if (r == 6) b = 8'h42;
      else if (r == 7) b = 8'h62;
      else b = 8'($urandom);
      send(b, tdo, $urandom_range(0, 6));
    end
    chk("accept_count", n_acc, n_sent);
    chk("resp_count", n_resp, n_rexp);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_jtag_bitbang.md
Name: uart_jtag_bitbang

Overview:
- Byte-stream command decoder that turns host characters into JTAG pin wiggles. It drives the SoC's tck/tms/tdi/trst_n and returns tdo samples.
- Sits between the FPGA-side UART byte interface and the SoC debug transport. It lets a host drive JTAG over the FTDI serial channel when raw JTAG pins are impractical.
- Command set is the remote-bitbang character protocol.

Parameters:
- HOLD_CYCLES, 4, clk cycles pins are held stable after each pin write before the next byte is accepted; 0 allowed.
- SYNC_STAGES, 2, flop stages on the tdo input synchroniser; minimum 2.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  reset: synchronous, active-high.
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts rx_data this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  response valid.
- tx_ready  in  1  sink accepts tx_data.
- tck  out  1  JTAG clock to SoC.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data in.
- tdo  in  1  JTAG data out from SoC; asynchronous to clk.
- trst_n  out  1  JTAG reset, active-low.
- srst_n  out  1  system reset request, active-low.
- led  out  1  host-controlled indicator.

Behaviour:
- Reset is synchronous. In any cycle with rst=1, on the next edge:
  - tck=0, tms=1, tdi=0, trst_n=1, srst_n=1, led=0.
  - tx_valid=0, tx_data=0, hold counter=0, state=IDLE.
  - tdo synchroniser flops cleared to 0.
- rx_ready=0 while rst=1.
- All outputs are registered except rx_ready, which equals (state==IDLE && !rst).
- A byte is accepted when rx_valid && rx_ready.
- FSM states: IDLE, HOLD, RESP.
- IDLE, on accept, decode by byte value:
  - '0'..'7' (0x30..0x37): tck=b[2], tms=b[1], tdi=b[0], updated on the accepting edge. Next state is HOLD with counter=HOLD_CYCLES-1. If HOLD_CYCLES==0, stay in IDLE, so back-to-back writes are possible at one per cycle.
  - 'R' (0x52): tx_data = tdo_sync ? 0x31 : 0x30, using the synchronised tdo value present in the accepting cycle. tx_valid=1; next state RESP.
  - 'r'/'s'/'t'/'u' (0x72..0x75): {trst,srst} = {0,0}/{0,1}/{1,0}/{1,1}, with trst_n=~trst and srst_n=~srst. Stay in IDLE.
  - 'B' (0x42): led=1. 'b' (0x62): led=0. Stay in IDLE.
  - Any other byte, including 'Q': consumed with no effect; stay in IDLE.
- HOLD:
  - rx_ready=0; the counter decrements each cycle.
  - When counter==0 in HOLD, next state is IDLE.
  - Total blocked cycles after the accepting edge = HOLD_CYCLES.
- RESP:
  - rx_ready=0; tx_valid and tx_data are held stable until tx_ready.
  - On tx_valid && tx_ready: tx_valid=0 next edge, state=IDLE.
  - tx_ready ignored while tx_valid=0.
- Pin outputs change only on a pin-write or reset command. They never glitch and stay stable during HOLD and RESP.
- tdo latency: a tdo change is visible in a response after SYNC_STAGES clk edges.
- Reset mid-HOLD or mid-RESP: any pending response is dropped (tx_valid=0) and pins return to reset values; the in-flight command is not replayed.
- rx_valid asserted during HOLD/RESP: the byte is held by the source; no loss, no duplication.

Decomposition:
- Package uart_jtag_bitbang_pkg:
  - Command byte constants: CMD_WR_BASE 0x30, CMD_READ 0x52, CMD_RST_BASE 0x72, CMD_LED_ON 0x42, CMD_LED_OFF 0x62.
  - Response constants: RESP_0 0x30, RESP_1 0x31.
  - FSM state encoding.
- Sub-module: sync_1bit (SYNC_STAGES-deep flop chain with synchronous active-high reset) for tdo. The same module is reusable for other async inputs.

Test Plan:
- Reset, then idle 5 cycles -> tck=0, tms=1, tdi=0, trst_n=1, srst_n=1, led=0, tx_valid=0, rx_ready=1.
- Send '5' (0x35), HOLD_CYCLES=4 -> tck=1, tms=0, tdi=1 after the accepting edge; rx_ready low exactly 4 cycles, then high.
- Hold tdo=1 for ≥3 cycles, send 'R', tx_ready held low 10 cycles -> tx_valid=1 with tx_data=0x31 stable throughout; one response only after tx_ready; repeat with tdo=0 -> 0x30.
- Send 't','u','r','B','b','Q' -> trst_n/srst_n go 0/1, 0/0, 1/1; led 1 then 0; 'Q' changes nothing; no tx_valid.
- HOLD_CYCLES=0, stream '1','3','0' with rx_valid continuous -> one accept per cycle; pins track each byte on consecutive edges.
- Assert rst during RESP with tx_ready=0 -> next edge tx_valid=0, pins at reset values; a subsequent 'R' produces exactly one response.
